// File: rtl/threeway_pkg.sv
// Shared types, constants and nonlinear/permutation helpers for the 3-Way
// cipher cores. Word packing throughout: a0 = [31:0], a1 = [63:32], a2 = [95:64].
package threeway_pkg;

  typedef logic [95:0] tw_block_t;
  typedef logic [31:0] tw_word_t;

  localparam int          NROUNDS      = 11;
  localparam logic [15:0] RC_START_ENC = 16'h0B0B;
  localparam logic [15:0] RC_START_DEC = 16'hB1B1;
  localparam logic [16:0] RC_POLY      = 17'h11011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } tw_state_t;

  // Full 96-bit reversal; equivalent to reversing each word and swapping a0/a2.
  function automatic tw_block_t mu(input tw_block_t x);
    tw_block_t r;
    for (int i = 0; i < 96; i++) begin
      r[i] = x[95-i];
    end
    return r;
  endfunction

  function automatic tw_block_t gamma(input tw_block_t x);
    tw_word_t a0;
    tw_word_t a1;
    tw_word_t a2;
    a0 = x[31:0];
    a1 = x[63:32];
    a2 = x[95:64];
    return {a2 ^ (a0 | ~a1), a1 ^ (a2 | ~a0), a0 ^ (a1 | ~a2)};
  endfunction

  function automatic tw_block_t pi_1(input tw_block_t x);
    tw_word_t a0;
    tw_word_t a2;
    a0 = x[31:0];
    a2 = x[95:64];
    return {{a2[30:0], a2[31]}, x[63:32], {a0[9:0], a0[31:10]}};
  endfunction

  function automatic tw_block_t pi_2(input tw_block_t x);
    tw_word_t a0;
    tw_word_t a2;
    a0 = x[31:0];
    a2 = x[95:64];
    return {{a2[9:0], a2[31:10]}, x[63:32], {a0[30:0], a0[31]}};
  endfunction

  function automatic logic [15:0] rc_step(input logic [15:0] rc);
    logic [16:0] t;
    t = {rc, 1'b0};
    if (t[16]) begin
      t = t ^ RC_POLY;
    end
    return t[15:0];
  endfunction

  // The round constant enters a0 shifted into the upper half and a2 unshifted.
  function automatic tw_block_t keyadd(input tw_block_t x, input tw_block_t k,
                                       input logic [15:0] rc);
    return {x[95:64] ^ k[95:64] ^ {16'h0000, rc},
            x[63:32] ^ k[63:32],
            x[31:0]  ^ k[31:0]  ^ {rc, 16'h0000}};
  endfunction

endpackage

// File: rtl/threeway_theta.sv
// 3-Way theta linear layer: purely combinational, shared with the encryption core.
module threeway_theta
  import threeway_pkg::*;
(
  input  logic [95:0] x_i,
  output logic [95:0] y_o
);

  // Each output word mixes its own word (a) with the next two (b, c) cyclically.
  function automatic tw_word_t theta_word(input tw_word_t a, input tw_word_t b,
                                          input tw_word_t c);
    return a ^ (a >> 16) ^ (b << 16) ^ (b >> 16) ^ (c << 16) ^
           (b >> 24) ^ (c << 8) ^ (c >> 8) ^ (a << 24) ^
           (c >> 16) ^ (a << 16) ^ (c >> 24) ^ (a << 8);
  endfunction

  tw_word_t w0;
  tw_word_t w1;
  tw_word_t w2;

  assign w0 = x_i[31:0];
  assign w1 = x_i[63:32];
  assign w2 = x_i[95:64];

  assign y_o = {theta_word(w2, w0, w1),
                theta_word(w1, w2, w0),
                theta_word(w0, w1, w2)};

endmodule

// File: rtl/threeway_decrypt.sv
// Iterative 3-Way decryption core: one rho round per clock, one block in flight,
// valid/ready handshakes on both sides.
module threeway_decrypt #(
  parameter int          NROUNDS  = 11,
  parameter logic [15:0] RC_START = 16'hB1B1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] key,
  input  logic [95:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] dout
);
  import threeway_pkg::*;

  localparam int CNT_W = $clog2(NROUNDS + 1);

  tw_state_t        fsm_q, fsm_d;
  tw_block_t        blk_q, blk_d;
  tw_block_t        kreg_q, kreg_d;
  logic [15:0]      rc_q, rc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tw_block_t        dout_q, dout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  tw_block_t blk_key;
  tw_block_t round_theta;
  tw_block_t round_out;
  tw_block_t shared_in;
  tw_block_t shared_theta;

  assign blk_key = keyadd(blk_q, kreg_q, rc_q);

  threeway_theta u_theta_round (
    .x_i (blk_key),
    .y_o (round_theta)
  );

  assign round_out = pi_2(gamma(pi_1(round_theta)));

  // Key inversion happens only in IDLE and the output transform only in DONE,
  // so one theta instance serves both.
  assign shared_in = (fsm_q == S_IDLE) ? key : blk_key;

  threeway_theta u_theta_shared (
    .x_i (shared_in),
    .y_o (shared_theta)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      blk_q       <= '0;
      kreg_q      <= '0;
      rc_q        <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      kreg_q      <= kreg_d;
      rc_q        <= rc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    kreg_d      = kreg_q;
    rc_d        = rc_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          blk_d      = mu(din);
          kreg_d     = mu(shared_theta);
          rc_d       = RC_START;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          fsm_d      = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out;
        rc_d  = rc_step(rc_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NROUNDS - 1)) begin
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        // First DONE cycle produces the result; later cycles wait for the sink.
        if (!out_valid_q) begin
          dout_d      = mu(shared_theta);
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fsm_d       = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_threeway_decrypt.sv
// Bench for threeway_decrypt: plaintexts are encrypted by a bench-side 3-Way
// encryption model, and the core must recover the original plaintext.
module tb_threeway_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] key;
  logic [95:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [95:0] exp_q[$];
  logic [95:0] drv_pt;
  bit          b2b_chk = 0;
  bit          hs_seen = 0;
  int          last_hs = 0;

  typedef struct {
    logic [95:0] k;
    logic [95:0] p;
  } vec_t;
  vec_t vecs[6];

  threeway_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] th(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c);
    return a ^ (a >> 16) ^ (b << 16) ^ (b >> 16) ^ (c << 16) ^
           (b >> 24) ^ (c << 8) ^ (c >> 8) ^ (a << 24) ^
           (c >> 16) ^ (a << 16) ^ (c >> 24) ^ (a << 8);
  endfunction

  // Forward 3-Way encryption, word-array form of the reference C code.
  function automatic logic [95:0] enc(input logic [95:0] k, input logic [95:0] p);
    logic [31:0] a[3];
    logic [31:0] t[3];
    logic [15:0] rc;
    rc   = 16'h0B0B;
    a[0] = p[31:0];
    a[1] = p[63:32];
    a[2] = p[95:64];
    for (int r = 0; r <= 11; r++) begin
      a[0] = a[0] ^ k[31:0] ^ {rc, 16'h0000};
      a[1] = a[1] ^ k[63:32];
      a[2] = a[2] ^ k[95:64] ^ {16'h0000, rc};
      t[0] = th(a[0], a[1], a[2]);
      t[1] = th(a[1], a[2], a[0]);
      t[2] = th(a[2], a[0], a[1]);
      a[0] = t[0];
      a[1] = t[1];
      a[2] = t[2];
      if (r < 11) begin
        a[0] = (a[0] >> 10) | (a[0] << 22);
        a[2] = (a[2] << 1) | (a[2] >> 31);
        t[0] = a[0] ^ (a[1] | ~a[2]);
        t[1] = a[1] ^ (a[2] | ~a[0]);
        t[2] = a[2] ^ (a[0] | ~a[1]);
        a[0] = (t[0] << 1) | (t[0] >> 31);
        a[1] = t[1];
        a[2] = (t[2] >> 10) | (t[2] << 22);
        rc   = {rc[14:0], 1'b0} ^ (rc[15] ? 16'h1011 : 16'h0000);
      end
    end
    return {a[2], a[1], a[0]};
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_pt);
        if (b2b_chk && hs_seen) chk("b2b_accept_gap", 96'(cyc + 1 - last_hs), 96'd1);
      end
      if (out_valid && out_ready) begin
        hs_seen = 1;
        last_hs = cyc + 1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got=%h expected=none", dout);
        end else begin
          chk("plaintext", dout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [95:0] k, input logic [95:0] p);
    int n = 0;
    @(posedge clk); #1;
    key      = k;
    din      = enc(k, p);
    drv_pt   = p;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int errs_d;
    int errs_r;
    logic [95:0] p1, p2, k1, k2;

    vecs[0] = '{k: 96'h0, p: 96'h00000001_00000001_00000001};
    vecs[1] = '{k: 96'h0, p: 96'h0};
    vecs[2] = '{k: {96{1'b1}}, p: 96'h0};
    vecs[3] = '{k: 96'h1, p: {96{1'b1}}};
    vecs[4] = '{k: 96'hDEADBEEF_01234567_89ABCDEF, p: 96'hCAFEF00D_12345678_9ABCDEF0};
    vecs[5] = '{k: 96'h80000000_00000000_00000001, p: 96'h00000000_80000000_00000000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key       = '0;
    din       = '0;
    drv_pt    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 96'(in_ready), 96'd1);
    chk("reset_out_valid", 96'(out_valid), 96'd0);
    chk("reset_dout", dout, 96'h0);
    rst = 1'b0;

    // Known answer with latency measured from the accept edge.
    @(posedge clk); #1;
    key      = '0;
    din      = enc(96'h0, 96'h00000001_00000001_00000001);
    drv_pt   = 96'h00000001_00000001_00000001;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("kat_latency", 96'(lat), 96'd13);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].k, vecs[i].p);
      wait_idle();
    end

    // Backpressure with a second block waiting on in_valid.
    k1 = 96'h11111111_22222222_33333333;
    p1 = 96'hA5A5A5A5_5A5A5A5A_0F0F0F0F;
    k2 = 96'h44444444_55555555_66666666;
    p2 = 96'h13579BDF_2468ACE0_FEDCBA98;
    out_ready = 1'b0;
    send(k1, p1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 96'(out_valid), 96'd1);
    key      = k2;
    din      = enc(k2, p2);
    drv_pt   = p2;
    in_valid = 1'b1;
    errs_d = 0;
    errs_r = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dout !== p1 || out_valid !== 1'b1) errs_d++;
      if (in_ready !== 1'b0) errs_r++;
    end
    chk("bp_dout_stable", 96'(errs_d), 96'd0);
    chk("bp_in_ready_low", 96'(errs_r), 96'd0);
    chk("bp_no_accept", 96'(exp_q.size()), 96'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handshake_valid", 96'(out_valid), 96'd0);
    chk("bp_handshake_ready", 96'(in_ready), 96'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", 96'(in_ready), 96'd0);
    wait_idle();

    // Back-to-back: in_valid never drops across three blocks.
    b2b_chk = 1;
    hs_seen = 0;
    @(posedge clk); #1;
    key      = vecs[4].k;
    din      = enc(vecs[4].k, vecs[4].p);
    drv_pt   = vecs[4].p;
    in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!in_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      if (b < 2) begin
        key    = vecs[b + 2].k;
        din    = enc(vecs[b + 2].k, vecs[b + 2].p);
        drv_pt = vecs[b + 2].p;
      end else begin
        in_valid = 1'b0;
      end
    end
    wait_idle();
    b2b_chk = 0;

    // Reset in the middle of the rounds.
    send(k1, p1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("midreset_out_valid", 96'(out_valid), 96'd0);
    chk("midreset_in_ready", 96'(in_ready), 96'd1);
    chk("midreset_dout", dout, 96'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(k2, p2);
    wait_idle();

    // Key input toggled while the block is being processed.
    send(k1, p2);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      key = {$urandom, $urandom, $urandom};
    end
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
